apb_timer_slave: RTL
====================

Name: apb_timer_slave

Overview:
- APB peripheral that sits directly downstream of the AHB-to-APB bridge and consumes its paddr/pwdata/psel/penable/pwrite, returning prdata.
- Implements a memory-mapped down-counting timer with a prescaler, one-shot or auto-reload modes, a sticky expiry flag and an interrupt output.
- The bridge has no pready/pslverr input, so every transfer completes with zero wait states and no error response.

Parameters:
- CNT_WIDTH, 32, width of LOAD/COUNT registers (1..32).
- PS_WIDTH, 16, width of PRESCALE register (1..32).
- ID_VALUE, 32'h5449_4D31, constant returned by ID register.

Ports:
- hclk  in  1  system clock; all state changes on rising edge.
- hreset  in  1  synchronous, active-high reset.
- psel  in  1  APB select from bridge.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address; only paddr[4:2] decoded, upper bits ignored.
- pwdata  in  32  write data.
- prdata  out  32  read data; registered.
- irq  out  1  interrupt = expired & CTRL.irq_en.

Behaviour:
- Reset (hreset=1 at a rising edge): CTRL=0, PRESCALE=0, LOAD=0, COUNT=0, prescale counter=0, expired=0, prdata=0, irq=0. Reset mid-transfer aborts it with no register side effect.
- Register map (paddr[4:2]):
  - 0x00 CTRL rw: [0] en, [1] auto_reload, [2] irq_en.
  - 0x04 PRESCALE rw, [PS_WIDTH-1:0].
  - 0x08 LOAD rw, [CNT_WIDTH-1:0].
  - 0x0C COUNT ro.
  - 0x10 STATUS: [0] expired, write-1-to-clear.
  - 0x14 ID ro = ID_VALUE.
  - 0x18/0x1C read 0, writes ignored. Unused read bits are 0.
- Write: committed at the rising edge where psel&penable&pwrite=1. Setup phase has no effect.
- Read: prdata loaded at the rising edge where psel&!penable&!pwrite=1 (setup phase) and held stable through the access phase and afterwards until the next read setup. Back-to-back transfers are supported.
- Write side effects:
  - LOAD write also sets COUNT=pwdata and clears the prescale counter.
  - CTRL write with en 0→1 clears the prescale counter.
- Prescaler, while en=1: pcnt increments each cycle. When pcnt==PRESCALE, pcnt←0 and a tick is generated. PRESCALE=0 gives a tick every cycle. Period = (PRESCALE+1)·(LOAD+1) cycles.
- On tick:
  - If COUNT≠0: COUNT←COUNT−1.
  - If COUNT==0: expired←1. If auto_reload=1, COUNT←LOAD. Otherwise (one-shot) en←0 and COUNT stays 0.
- en=0: pcnt and COUNT hold.
- Simultaneous events:
  - CTRL write and one-shot tick in the same cycle: the written CTRL value wins.
  - LOAD write and tick in the same cycle: the load wins; the tick is discarded.
  - STATUS W1C and a new expiry in the same cycle: set wins, so expired=1.
- LOAD=0 with auto_reload: expired sets on every tick.
- Arithmetic: no wrap below 0. Values wider than the register width are truncated on write.
- irq is combinational from the expired and irq_en flops; it asserts the same cycle expired becomes 1.

Test Plan:
- Reset then read all registers → CTRL/PRESCALE/LOAD/COUNT/STATUS = 0, ID = 32'h5449_4D31, addr 0x18 reads 0, irq=0.
- Write LOAD=3, PRESCALE=0, CTRL=0x5 (one-shot, irq_en) → COUNT 3,2,1,0 on successive cycles. expired=1 and irq=1 on the 4th tick after the enable edge. CTRL.en reads 0. COUNT holds 0 for 20 further cycles.
- LOAD=2, PRESCALE=4, CTRL=0x3 (auto-reload) → expired first sets 15 cycles after enable. COUNT reloads to 2. Write STATUS=1 → expired=0, then sets again 15 cycles later.
- Read COUNT while running (PRESCALE=0, LOAD=100) → prdata equals COUNT at the setup edge and stays constant during penable.
- Coincident STATUS W1C on the cycle expired would set → expired remains 1. LOAD write (value 7) on a tick cycle → COUNT=7 next cycle, not decremented.
- Assert hreset during a write access phase to LOAD=0xAA → LOAD reads 0 afterwards. Write to COUNT (0x0C) → COUNT unchanged.

Source files
------------

// File: rtl/apb_timer_slave.sv
// APB down-counting timer with prescaler, one-shot / auto-reload modes,
// sticky expiry flag and interrupt output. Zero-wait-state slave.
module apb_timer_slave #(
  parameter int          CNT_WIDTH = 32,
  parameter int          PS_WIDTH  = 16,
  parameter logic [31:0] ID_VALUE  = 32'h5449_4D31
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq
);

  logic                 en;
  logic                 auto_reload;
  logic                 irq_en;
  logic [PS_WIDTH-1:0]  prescale;
  logic [PS_WIDTH-1:0]  pcnt;
  logic [CNT_WIDTH-1:0] load;
  logic [CNT_WIDTH-1:0] count;
  logic                 expired;
  logic [31:0]          rdata;

  logic [2:0] idx;
  logic       wr_acc;
  logic       rd_setup;
  logic       s_ctrl;
  logic       s_ps;
  logic       s_load;
  logic       s_count;
  logic       s_status;
  logic       s_id;

  logic wr_ctrl;
  logic wr_ps;
  logic wr_load;
  logic wr_status;
  logic en_rise;
  logic ps_hit;
  logic tick;
  logic at_zero;
  logic expire;

  assign idx      = paddr[4:2];
  assign wr_acc   = psel & penable & pwrite;
  assign rd_setup = psel & ~penable & ~pwrite;

  assign s_ctrl   = (idx == 3'd0);
  assign s_ps     = (idx == 3'd1);
  assign s_load   = (idx == 3'd2);
  assign s_count  = (idx == 3'd3);
  assign s_status = (idx == 3'd4);
  assign s_id     = (idx == 3'd5);

  assign wr_ctrl   = wr_acc & s_ctrl;
  assign wr_ps     = wr_acc & s_ps;
  assign wr_load   = wr_acc & s_load;
  assign wr_status = wr_acc & s_status;

  assign en_rise = wr_ctrl & pwdata[0] & ~en;

  // >= rather than == so that shrinking PRESCALE below a running
  // pcnt ticks at once instead of wrapping through the full range.
  assign ps_hit  = (pcnt >= prescale);

  // A LOAD write swallows any tick landing in the same cycle.
  assign tick    = en & ps_hit & ~wr_load;
  assign at_zero = (count == '0);
  assign expire  = tick & at_zero;

  assign irq = expired & irq_en;

  // Control bits; a one-shot expiry drops en unless CTRL is being written.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
    end else if (wr_ctrl) begin
      en          <= pwdata[0];
      auto_reload <= pwdata[1];
      irq_en      <= pwdata[2];
    end else if (expire & ~auto_reload) begin
      en <= 1'b0;
    end
  end

  // PRESCALE and LOAD configuration registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      prescale <= '0;
      load     <= '0;
    end else begin
      if (wr_ps)
        prescale <= pwdata[PS_WIDTH-1:0];
      if (wr_load)
        load <= pwdata[CNT_WIDTH-1:0];
    end
  end

  // Prescale counter, restarted by LOAD writes and enable rising.
  always_ff @(posedge hclk) begin
    if (hreset)
      pcnt <= '0;
    else if (wr_load | en_rise)
      pcnt <= '0;
    else if (en)
      pcnt <= ps_hit ? '0 : pcnt + 1'b1;
  end

  // Main down counter; saturates at zero or reloads on expiry.
  always_ff @(posedge hclk) begin
    if (hreset)
      count <= '0;
    else if (wr_load)
      count <= pwdata[CNT_WIDTH-1:0];
    else if (tick) begin
      if (!at_zero)
        count <= count - 1'b1;
      else if (auto_reload)
        count <= load;
    end
  end

  // Sticky expiry flag; a new expiry beats a same-cycle clear.
  always_ff @(posedge hclk) begin
    if (hreset)
      expired <= 1'b0;
    else if (expire)
      expired <= 1'b1;
    else if (wr_status & pwdata[0])
      expired <= 1'b0;
  end

  // Read mux; unused bits and unmapped offsets return zero.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      s_ctrl:   rdata[2:0] = {irq_en, auto_reload, en};
      s_ps:     rdata[PS_WIDTH-1:0] = prescale;
      s_load:   rdata[CNT_WIDTH-1:0] = load;
      s_count:  rdata[CNT_WIDTH-1:0] = count;
      s_status: rdata[0] = expired;
      s_id:     rdata = ID_VALUE;
      default:  rdata = '0;
    endcase
  end

  // Read data captured in the setup phase and held until the next read.
  always_ff @(posedge hclk) begin
    if (hreset)
      prdata <= '0;
    else if (rd_setup)
      prdata <= rdata;
  end

endmodule
